sprite_pal_rom: RTL and testbench

Parametrised sprite store for the video pipeline. It holds `NUM_FRAMES` animation frames of `SPR_W`×`SPR_H` palette-indexed pixels and a writable 24-bit palette. It resolves orientation (R/L/U/D) in address space, so one right-facing frame set serves all four directions, and advances its animation frame from a per-video-frame tick. It sits between the sprite-position/draw logic and the colour mapper, replacing per-direction, per-frame RAM instances.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_pal_lut.sv | 48 ++++
 rtl/sprite_pal_rom.sv | 160 ++++++++++++++++
 tb/tb_sprite_pal_rom.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite stores (pixel ROMs and palettes).
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package sprite_pkg;

  // Sprite orientation; all four are derived from one right-facing frame set.
  typedef enum logic [1:0] {
    OR_R = 2'd0,
    OR_L = 2'd1,
    OR_U = 2'd2,
    OR_D = 2'd3
  } orient_t;

  localparam int RGB_W = 24;

  localparam logic [RGB_W-1:0] PAL_BLACK  = 24'h000000;
  localparam logic [RGB_W-1:0] PAL_YELLOW = 24'hFFFB01;

  // Address/counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_pal_lut.sv
// Palette RAM: registered read port plus an independent write port.
// Latency: 1 cycle from rd_en to rd_data; reads are read-before-write.
// Backpressure: none; a read and a write are accepted every cycle.
//
// Ports: Clk/Reset_n (sync, active-low; clears rd_data only, never contents),
//        rd_en/rd_addr -> rd_data (holds when rd_en=0),
//        we/waddr/wdata palette update.
module sprite_pal_lut
  import sprite_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int DEPTH = 32,
  localparam int AW   = clog2_min1(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [RGB_W-1:0] rd_data,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [RGB_W-1:0] wdata
);

  // Power-up palette: entry 1 is the sprite body colour, the rest black.
  logic [RGB_W-1:0] mem [DEPTH] = '{0: PAL_BLACK, 1: PAL_YELLOW, default: PAL_BLACK};

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Separate process from the write, so a same-edge access sees old data.
  // Indices beyond the populated depth read as black.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if (int'(rd_addr) < DEPTH) begin
        rd_data <= mem[rd_addr[AW-1:0]];
      end else begin
        rd_data <= PAL_BLACK;
      end
    end
  end

endmodule

// File: rtl/sprite_pal_rom.sv
// Animated, orientation-aware sprite pixel store feeding a writable palette.
// Latency: 3 cycles, request to out_valid; one request per cycle.
// Backpressure: none; requests and both write ports are accepted every cycle.
//
// Ports: Clk/Reset_n (sync, active-low; pipeline and animation state only),
//        rd_valid/rd_x/rd_y/orient lookup request in output space,
//        frame_tick/anim_en animation advance, cur_frame current frame,
//        pix_we/pix_waddr/pix_wdata and pal_we/pal_waddr/pal_wdata writes,
//        out_valid/out_rgb/out_transparent result (held while out_valid=0).
module sprite_pal_rom
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int NUM_FRAMES = 2,
  parameter int IDX_W      = 5,
  parameter int PAL_DEPTH  = 32,
  parameter int ANIM_DIV   = 8,
  parameter     INIT_FILE  = "",
  // Coordinates carry one code past the sprite edge so off-sprite pixels
  // can be requested and come back transparent.
  localparam int XW        = $clog2(SPR_W + 1),
  localparam int YW        = $clog2(SPR_H + 1),
  localparam int PIX_DEPTH = NUM_FRAMES * SPR_W * SPR_H,
  localparam int PIX_AW    = clog2_min1(PIX_DEPTH),
  localparam int PAL_AW    = clog2_min1(PAL_DEPTH),
  localparam int FRM_W     = clog2_min1(NUM_FRAMES),
  localparam int CNT_W     = clog2_min1(ANIM_DIV)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              rd_valid,
  input  logic [XW-1:0]     rd_x,
  input  logic [YW-1:0]     rd_y,
  input  logic [1:0]        orient,
  input  logic              frame_tick,
  input  logic              anim_en,
  input  logic              pix_we,
  input  logic [PIX_AW-1:0] pix_waddr,
  input  logic [IDX_W-1:0]  pix_wdata,
  input  logic              pal_we,
  input  logic [PAL_AW-1:0] pal_waddr,
  input  logic [RGB_W-1:0]  pal_wdata,
  output logic              out_valid,
  output logic [RGB_W-1:0]  out_rgb,
  output logic              out_transparent,
  output logic [FRM_W-1:0]  cur_frame
);

  logic [IDX_W-1:0] pix_mem [PIX_DEPTH];

  always_ff @(posedge Clk) begin
    if (pix_we) begin
      pix_mem[pix_waddr] <= pix_wdata;
    end
  end

  // ---------------- animation ----------------
  logic [CNT_W-1:0] anim_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      anim_cnt  <= '0;
      cur_frame <= '0;
    end else if (frame_tick && anim_en) begin
      if (anim_cnt == CNT_W'(ANIM_DIV - 1)) begin
        anim_cnt  <= '0;
        cur_frame <= (cur_frame == FRM_W'(NUM_FRAMES - 1)) ? '0 : cur_frame + FRM_W'(1);
      end else begin
        anim_cnt <= anim_cnt + CNT_W'(1);
      end
    end
  end

  // ---------------- address transform ----------------
  // Orientation is a coordinate remap into the right-facing source frame.
  // U/D swap axes, which only makes sense for square sprites.
  int               sx;
  int               sy;
  logic             in_range;
  logic [PIX_AW-1:0] addr_c;

  always_comb begin
    sx = int'(rd_x);
    sy = int'(rd_y);
    case (orient_t'(orient))
      OR_L: sx = SPR_W - 1 - int'(rd_x);
      OR_U: begin
        sx = SPR_H - 1 - int'(rd_y);
        sy = int'(rd_x);
      end
      OR_D: begin
        sx = int'(rd_y);
        sy = SPR_W - 1 - int'(rd_x);
      end
      default: ;
    endcase
    in_range = (int'(rd_x) < SPR_W) && (int'(rd_y) < SPR_H);
    // Off-sprite requests park on address 0; their colour is discarded.
    addr_c = in_range ? PIX_AW'(int'(cur_frame) * SPR_W * SPR_H + sy * SPR_W + sx) : '0;
  end

  // ---------------- pipeline ----------------
  logic              s1_vld;
  logic [PIX_AW-1:0] s1_addr;
  logic              s1_oor;
  logic              s2_vld;
  logic [IDX_W-1:0]  s2_idx;
  logic              s2_oor;
  logic              s3_oor;
  logic [RGB_W-1:0]  pal_rgb;

  // Data registers load only with their valid, so outputs hold between
  // results; reset clears valids (dropping in-flight work) and the
  // output-facing state.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      s1_vld          <= 1'b0;
      s2_vld          <= 1'b0;
      out_valid       <= 1'b0;
      out_transparent <= 1'b0;
      s3_oor          <= 1'b0;
    end else begin
      s1_vld <= rd_valid;
      if (rd_valid) begin
        s1_addr <= addr_c;
        s1_oor  <= !in_range;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_idx <= pix_mem[s1_addr];
        s2_oor <= s1_oor;
      end
      out_valid <= s2_vld;
      if (s2_vld) begin
        out_transparent <= s2_oor || (s2_idx == '0);
        s3_oor          <= s2_oor;
      end
    end
  end

  sprite_pal_lut #(
    .IDX_W (IDX_W),
    .DEPTH (PAL_DEPTH)
  ) u_pal (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .rd_en   (s2_vld),
    .rd_addr (s2_idx),
    .rd_data (pal_rgb),
    .we      (pal_we),
    .waddr   (pal_waddr),
    .wdata   (pal_wdata)
  );

  // Palette read and off-sprite flag are both registered in the same stage;
  // off-sprite results report black rather than palette[0].
  assign out_rgb = s3_oor ? '0 : pal_rgb;

endmodule

// File: tb/tb_sprite_pal_rom.sv
module tb_sprite_pal_rom;
  import sprite_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        rd_valid = 1'b0;
  logic [4:0]  rd_x = '0;
  logic [4:0]  rd_y = '0;
  logic [1:0]  orient = '0;
  logic        frame_tick = 1'b0;
  logic        anim_en = 1'b0;
  logic        pix_we = 1'b0;
  logic [8:0]  pix_waddr = '0;
  logic [4:0]  pix_wdata = '0;
  logic        pal_we = 1'b0;
  logic [4:0]  pal_waddr = '0;
  logic [23:0] pal_wdata = '0;
  logic        out_valid;
  logic [23:0] out_rgb;
  logic        out_transparent;
  logic [0:0]  cur_frame;

  sprite_pal_rom dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .rd_valid        (rd_valid),
    .rd_x            (rd_x),
    .rd_y            (rd_y),
    .orient          (orient),
    .frame_tick      (frame_tick),
    .anim_en         (anim_en),
    .pix_we          (pix_we),
    .pix_waddr       (pix_waddr),
    .pix_wdata       (pix_wdata),
    .pal_we          (pal_we),
    .pal_waddr       (pal_waddr),
    .pal_wdata       (pal_wdata),
    .out_valid       (out_valid),
    .out_rgb         (out_rgb),
    .out_transparent (out_transparent),
    .cur_frame       (cur_frame)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] rgb;
    logic        tr;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          run_len = 0;
  int          max_run = 0;
  logic [4:0]  pix_m [512];
  logic [23:0] pal_m [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every out_valid pops one expectation (colour, flag, latency).
  always @(negedge Clk) begin
    if (out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got out_valid=1 at cycle %0d, required no output", cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk({mon_e.name, "_rgb"}, {8'h0, out_rgb}, {8'h0, mon_e.rgb});
        chk({mon_e.name, "_transp"}, {31'h0, out_transparent}, {31'h0, mon_e.tr});
        chk({mon_e.name, "_latency"}, cyc, mon_e.cyc + 3);
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic next();
    @(posedge Clk);
    #1;
  endtask

  task automatic req(input int x, input int y, input logic [1:0] o,
                     input logic [23:0] rgb, input logic tr, input string nm,
                     input bit track = 1'b1);
    rd_valid = 1'b1;
    rd_x     = x[4:0];
    rd_y     = y[4:0];
    orient   = o;
    if (track) begin
      exp_t e;
      e.rgb  = rgb;
      e.tr   = tr;
      e.cyc  = cyc;
      e.name = nm;
      sbq.push_back(e);
    end
    next();
    rd_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sbq.size() != 0; i++) next();
    chk("drain_empty", sbq.size(), 0);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    next();
    frame_tick = 1'b0;
  endtask

  task automatic palw(input int a, input logic [23:0] d);
    pal_we    = 1'b1;
    pal_waddr = a[4:0];
    pal_wdata = d;
    next();
    pal_we   = 1'b0;
    pal_m[a] = d;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    // ---- reset state ----
    repeat (3) next();
    chk("rst_out_valid", {31'h0, out_valid}, 0);
    chk("rst_out_rgb", {8'h0, out_rgb}, 0);
    chk("rst_out_transp", {31'h0, out_transparent}, 0);
    chk("rst_cur_frame", {31'h0, cur_frame}, 0);
    Reset_n = 1'b1;
    next();

    // ---- pixel / palette preload ----
    for (int a = 0; a < 512; a++) pix_m[a] = (a < 256 && (a % 9) == 4) ? 5'd2 : 5'd0;
    pix_m[3]   = 5'd1;   // frame0 (3,0)
    pix_m[5]   = 5'd2;   // frame0 (5,0)
    pix_m[21]  = 5'd3;   // frame0 (5,1)
    pix_m[259] = 5'd3;   // frame1 (3,0)
    pix_m[277] = 5'd1;   // frame1 (5,1)
    for (int a = 0; a < 512; a++) begin
      pix_we    = 1'b1;
      pix_waddr = a[8:0];
      pix_wdata = pix_m[a];
      next();
    end
    pix_we = 1'b0;
    for (int i = 0; i < 32; i++) pal_m[i] = 24'h000000;
    pal_m[1] = 24'hFFFB01;
    palw(2, 24'h123456);
    palw(3, 24'hABCDEF);

    // ---- orientation: same source pixels via R/L/U/D ----
    req(3, 0, OR_R, 24'hFFFB01, 1'b0, "r_3_0");
    req(12, 0, OR_L, 24'hFFFB01, 1'b0, "l_12_0");
    req(0, 12, OR_U, 24'hFFFB01, 1'b0, "u_0_12");
    req(15, 3, OR_D, 24'hFFFB01, 1'b0, "d_15_3");
    req(5, 0, OR_R, 24'h123456, 1'b0, "r_5_0");
    req(10, 0, OR_L, 24'h123456, 1'b0, "l_10_0");
    req(5, 1, OR_R, 24'hABCDEF, 1'b0, "r_5_1");
    req(1, 10, OR_U, 24'hABCDEF, 1'b0, "u_1_10");
    req(14, 5, OR_D, 24'hABCDEF, 1'b0, "d_14_5");
    req(0, 0, OR_R, 24'h000000, 1'b1, "idx0");
    req(16, 0, OR_R, 24'h000000, 1'b1, "oor_x");
    req(0, 16, OR_R, 24'h000000, 1'b1, "oor_y");
    drain();

    // ---- animation ----
    anim_en = 1'b1;
    repeat (3) tick();
    anim_en = 1'b0;
    repeat (5) tick();
    chk("anim_hold", {31'h0, cur_frame}, 0);
    anim_en = 1'b1;
    repeat (4) tick();
    chk("anim_tick7", {31'h0, cur_frame}, 0);
    tick();
    chk("anim_tick8", {31'h0, cur_frame}, 1);
    req(3, 0, OR_R, 24'hABCDEF, 1'b0, "f1_r_3_0");
    req(5, 1, OR_R, 24'hFFFB01, 1'b0, "f1_r_5_1");
    repeat (7) tick();
    chk("anim_tick15", {31'h0, cur_frame}, 1);
    frame_tick = 1'b1;               // wrapping tick on the same edge as a request
    req(3, 0, OR_R, 24'hABCDEF, 1'b0, "wrap_edge_old_frame");
    frame_tick = 1'b0;
    chk("anim_tick16", {31'h0, cur_frame}, 0);
    req(3, 0, OR_R, 24'hFFFB01, 1'b0, "after_wrap");
    anim_en = 1'b0;
    drain();

    // ---- palette write, same-cycle read-before-write ----
    palw(1, 24'h2033FF);
    req(3, 0, OR_R, 24'h2033FF, 1'b0, "pal1_new");
    req(3, 0, OR_R, 24'h2033FF, 1'b0, "pal_rbw_old");
    next();
    pal_we    = 1'b1;                // lands on the edge that reads the palette
    pal_waddr = 5'd1;
    pal_wdata = 24'h00FF00;
    next();
    pal_we   = 1'b0;
    pal_m[1] = 24'h00FF00;
    req(3, 0, OR_R, 24'h00FF00, 1'b0, "pal_rbw_new");
    req(5, 0, OR_R, 24'h123456, 1'b0, "pix_rbw_old");
    pix_we    = 1'b1;                // lands on the edge that reads pixel memory
    pix_waddr = 9'd5;
    pix_wdata = 5'd3;
    next();
    pix_we   = 1'b0;
    pix_m[5] = 5'd3;
    req(5, 0, OR_R, 24'hABCDEF, 1'b0, "pix_rbw_new");
    palw(0, 24'h0A0B0C);
    req(0, 0, OR_R, 24'h0A0B0C, 1'b1, "idx0_pal0");
    req(16, 0, OR_R, 24'h000000, 1'b1, "oor_rgb0");
    drain();

    // ---- full-throughput burst ----
    max_run = 0;
    run_len = 0;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 16; x++) begin
        req(x, y, OR_R, pal_m[pix_m[y*16+x]], (pix_m[y*16+x] == 5'd0), "burst");
      end
    end
    drain();
    chk("burst_run_len", max_run, 256);

    // ---- reset with requests in flight ----
    req(3, 0, OR_R, 24'h0, 1'b0, "", 1'b0);
    req(5, 1, OR_R, 24'h0, 1'b0, "", 1'b0);
    Reset_n = 1'b0;
    next();
    chk("midrst_out_valid", {31'h0, out_valid}, 0);
    chk("midrst_out_rgb", {8'h0, out_rgb}, 0);
    chk("midrst_out_transp", {31'h0, out_transparent}, 0);
    repeat (3) next();
    chk("midrst_out_valid_later", {31'h0, out_valid}, 0);
    Reset_n = 1'b1;
    next();
    req(3, 0, OR_R, 24'h00FF00, 1'b0, "post_rst_pix3");
    req(5, 0, OR_R, 24'hABCDEF, 1'b0, "post_rst_pix5");
    req(5, 1, OR_R, 24'hABCDEF, 1'b0, "post_rst_pix21");
    drain();
    chk("post_rst_cur_frame", {31'h0, cur_frame}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
